// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit-side arbiter and its neighbours.
// Header states exist only when UART_TX_ARB_ID_EN is defined.
package uart_pkg;

    localparam int unsigned UART_DATA_W  = 8;
    localparam logic [3:0]  UART_HDR_TAG = 4'hA;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitBusy,
        StWaitDone
`ifdef UART_TX_ARB_ID_EN
        ,
        StHdrStart,
        StHdrWaitBusy,
        StHdrWaitDone
`endif
    } arb_state_t;

    // Header byte identifying the source of the payload frame that follows it.
    function automatic logic [UART_DATA_W-1:0] hdr_byte(logic [2:0] id);
        return {UART_HDR_TAG, 1'b0, id};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer-side handshake and transmitter-side launch signals of the UART TX arbiter.
// master: the arbiter; slave: the producers/transmitter environment.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    import uart_pkg::*;

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*UART_DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           tx_start;
    logic [UART_DATA_W-1:0]         tx_data;
    logic                           tx_busy;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_start, tx_data
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_start, tx_data
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: one-hot grant to the first requester after `last`.
// Shared with the receive-side dispatcher, so it carries no state.
module rr_pick #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] k;

    // Walk from the farthest candidate to the nearest so the nearest valid one wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        k   = '0;
        for (int i = int'(N); i >= 1; i--) begin
            k = IDX_W'((int'(last) + i) % int'(N));
            if (req[k]) begin
                gnt    = '0;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// Define UART_TX_ARB_ID_EN to precede each payload frame with a source-id header frame.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned NUM_REQ      = 4,
    parameter  int unsigned BUSY_TIMEOUT = 8,
    localparam int unsigned IDX_W        = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_tx_arbiter_if.master      bus,
    output logic [IDX_W-1:0]       grant_id,
    output logic                   active,
    output logic                   err_timeout
);

    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

    arb_state_t             state_q, state_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic                   active_q, active_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic [UART_DATA_W-1:0] win_byte;
    logic                   timeout_hit;
`ifdef UART_TX_ARB_ID_EN
    logic [UART_DATA_W-1:0] payload_q, payload_d;
`endif

    rr_pick #(
        .N(NUM_REQ)
    ) u_rr_pick (
        .req (bus.req_valid),
        .last(last_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (pick_gnt[i]) win_byte = bus.req_data[i*UART_DATA_W +: UART_DATA_W];
        end
    end

    assign timeout_hit = (cnt_q == CNT_W'(BUSY_TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        grant_d       = grant_q;
        last_d        = last_q;
        active_d      = active_q;
        err_d         = err_q;
        cnt_d         = cnt_q;
`ifdef UART_TX_ARB_ID_EN
        payload_d     = payload_q;
`endif
        bus.req_ready = '0;
        bus.tx_start  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!bus.tx_busy && |bus.req_valid) begin
                    bus.req_ready = pick_gnt;
                    grant_d       = pick_idx;
                    last_d        = pick_idx;
                    active_d      = 1'b1;
`ifdef UART_TX_ARB_ID_EN
                    tx_data_d     = hdr_byte(3'(pick_idx));
                    payload_d     = win_byte;
                    state_d       = StHdrStart;
`else
                    tx_data_d     = win_byte;
                    state_d       = StStart;
`endif
                end
            end
            StStart: begin
                bus.tx_start = 1'b1;
                cnt_d        = '0;
                state_d      = StWaitBusy;
            end
            StWaitBusy: begin
                if (bus.tx_busy) begin
                    state_d = StWaitDone;
                end else if (timeout_hit) begin
                    err_d    = 1'b1;
                    active_d = 1'b0;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!bus.tx_busy) begin
                    active_d = 1'b0;
                    state_d  = StIdle;
                end
            end
`ifdef UART_TX_ARB_ID_EN
            StHdrStart: begin
                bus.tx_start = 1'b1;
                cnt_d        = '0;
                state_d      = StHdrWaitBusy;
            end
            StHdrWaitBusy: begin
                if (bus.tx_busy) begin
                    state_d = StHdrWaitDone;
                end else if (timeout_hit) begin
                    err_d    = 1'b1;
                    active_d = 1'b0;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Header frame done: swap in the payload and launch it without re-arbitrating.
            StHdrWaitDone: begin
                if (!bus.tx_busy) begin
                    tx_data_d = payload_q;
                    state_d   = StStart;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            tx_data_q <= '0;
            grant_q   <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            active_q  <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
`ifdef UART_TX_ARB_ID_EN
            payload_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            active_q  <= active_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
`ifdef UART_TX_ARB_ID_EN
            payload_q <= payload_d;
`endif
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign grant_id     = grant_q;
    assign active       = active_q;
    assign err_timeout  = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level model plus directed scenarios.
// Header scenario runs only when UART_TX_ARB_ID_EN is defined.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned BT = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] grant_id;
    logic       active;
    logic       err_timeout;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ     (NR),
        .BUSY_TIMEOUT(BT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .grant_id   (grant_id),
        .active     (active),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transmitter model: busy from 2 cycles after a start, for 40 cycles.
    int cyc = 0;
    bit busy_force = 1'b0;
    bit tx_never   = 1'b0;
    bit tx_have    = 1'b0;
    bit model_busy = 1'b0;
    int tx_st      = 0;
    assign bus.tx_busy = busy_force | model_busy;

    always @(posedge clk) cyc++;
    always @(posedge clk) begin
        #1;
        model_busy = tx_have && (cyc >= tx_st + 2) && (cyc < tx_st + 42);
    end

    typedef struct {
        int data;
        int gid;
        int cyc;
    } launch_t;
    launch_t launches[$];
    int hs_count = 0;
    int err_cyc  = -1;

    function automatic launch_t lq(int i);
        launch_t none = '{-1, -1, -1};
        if (i < launches.size()) return launches[i];
        return none;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            tx_have = 1'b0;
            err_cyc = -1;
        end else begin
            if (bus.tx_start) begin
                if (!tx_never) begin
                    tx_have = 1'b1;
                    tx_st   = cyc;
                end
                launches.push_back('{int'(bus.tx_data), int'(grant_id), cyc});
            end
            if (|(bus.req_ready & bus.req_valid)) hs_count++;
            if (err_timeout && err_cyc < 0) err_cyc = cyc;
        end
    end

    // Reference model: one frame (or header+payload pair) in flight per grant.
    int         m_last = -1;
    bit         m_active, m_start, m_busy_seen, m_err, m_hdr;
    int         m_waited;
    logic [7:0] m_data, m_payload;
    logic [1:0] m_gid;

    function automatic int rr_index(logic [3:0] v, int last);
        for (int i = 1; i <= 4; i++) begin
            int k = (last + i + 4) % 4;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_ready_now();
        int w;
        if (reset || m_active || bus.tx_busy) return 4'b0;
        w = rr_index(bus.req_valid, m_last);
        if (w < 0) return 4'b0;
        return 4'(1 << w);
    endfunction

    always @(posedge clk or posedge reset) begin
        int w;
        if (reset) begin
            m_last = -1; m_active = 0; m_start = 0; m_busy_seen = 0; m_err = 0; m_hdr = 0;
            m_waited = 0; m_data = 8'h00; m_payload = 8'h00; m_gid = 2'd0;
        end else if (!m_active) begin
            w = bus.tx_busy ? -1 : rr_index(bus.req_valid, m_last);
            if (w >= 0) begin
                m_last = w; m_gid = 2'(w); m_active = 1; m_start = 1;
`ifdef UART_TX_ARB_ID_EN
                m_hdr = 1; m_payload = bus.req_data[w*8 +: 8];
                m_data = {4'hA, 1'b0, 3'(w)};
`else
                m_data = bus.req_data[w*8 +: 8];
`endif
            end
        end else if (m_start) begin
            m_start = 0; m_waited = 0; m_busy_seen = 0;
        end else if (!m_busy_seen) begin
            if (bus.tx_busy) m_busy_seen = 1;
            else begin
                m_waited++;
                if (m_waited == int'(BT)) begin
                    m_err = 1; m_active = 0; m_hdr = 0;
                end
            end
        end else if (!bus.tx_busy) begin
            if (m_hdr) begin
                m_hdr = 0; m_data = m_payload; m_start = 1;
            end else begin
                m_active = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("req_ready", 32'(bus.req_ready), 32'(m_ready_now()));
        check("tx_start", 32'(bus.tx_start), 32'(m_start));
        check("tx_data", 32'(bus.tx_data), 32'(m_data));
        check("grant_id", 32'(grant_id), 32'(m_gid));
        check("active", 32'(active), 32'(m_active));
        check("err_timeout", 32'(err_timeout), 32'(m_err));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_byte(int k, logic [7:0] b);
        bus.req_data[k*8 +: 8] = b;
    endtask

    task automatic wait_launch(int n, string name);
        int k = 0;
        while (launches.size() < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(launches.size() >= n), 32'd1);
        tick();
    endtask

    task automatic wait_idle(string name);
        int k = 0;
        while ((active || bus.tx_busy) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(active), 32'd0);
        tick();
    endtask

    initial begin
        int base;
        int hs0;
        int rel;
        bus.req_valid = '0;
        bus.req_data  = '0;
        repeat (3) tick();
        check("rst_tx_data", 32'(bus.tx_data), 32'h00);
        check("rst_active", 32'(active), 32'd0);
        reset = 1'b0;

        // Single request from requester 2.
        base = launches.size();
        set_byte(2, 8'h5A);
        bus.req_valid = 4'b0100;
        wait_launch(base + 1, "t1_launch");
        bus.req_valid = '0;
        wait_idle("t1_idle");
        repeat (3) tick();
        check("t1_data", 32'(lq(base).data), 32'h5A);
        check("t1_gid", 32'(lq(base).gid), 32'd2);
        check("t1_one_start", 32'(launches.size() - base), 32'd1);

        // All requesters valid from reset: strict rotation, 44-cycle launch spacing.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        base = launches.size();
        for (int i = 0; i < 4; i++) set_byte(i, 8'(8'h10 + i));
        bus.req_valid = 4'hF;
        wait_launch(base + 5, "t2_launch");
        bus.req_valid = '0;
        wait_idle("t2_idle");
        for (int i = 0; i < 5; i++) begin
            check("t2_data", 32'(lq(base + i).data), 32'(8'h10 + (i % 4)));
            check("t2_gid", 32'(lq(base + i).gid), 32'(i % 4));
        end
        for (int i = 1; i < 5; i++) begin
            check("t2_spacing", 32'(lq(base + i).cyc - lq(base + i - 1).cyc), 32'd44);
        end

        // Busy at idle blocks acceptance; release accepts on the next edge.
        busy_force = 1'b1;
        set_byte(0, 8'h77);
        bus.req_valid = 4'b0001;
        repeat (5) tick();
        check("t3_ready_blocked", 32'(bus.req_ready), 32'd0);
        base = launches.size();
        rel = cyc;
        busy_force = 1'b0;
        wait_launch(base + 1, "t3_launch");
        bus.req_valid = '0;
        check("t3_latency", 32'(lq(base).cyc - rel), 32'd1);
        check("t3_data", 32'(lq(base).data), 32'h77);
        wait_idle("t3_idle");

        // Transmitter never goes busy: timeout, then the next request is served.
        tx_never = 1'b1;
        base = launches.size();
        set_byte(1, 8'h3C);
        bus.req_valid = 4'b0010;
        wait_launch(base + 1, "t4_launch");
        bus.req_valid = '0;
        wait_idle("t4_idle");
        check("t4_err", 32'(err_timeout), 32'd1);
        check("t4_err_time", 32'(err_cyc - lq(base).cyc), 32'(BT + 1));
        tx_never = 1'b0;
        set_byte(3, 8'hE1);
        bus.req_valid = 4'b1000;
        wait_launch(base + 2, "t4_next_launch");
        bus.req_valid = '0;
        check("t4_next_data", 32'(lq(base + 1).data), 32'hE1);
        check("t4_next_gid", 32'(lq(base + 1).gid), 32'd3);
        wait_idle("t4_next_idle");

        // Reset during a frame, then requester 0 wins first.
        base = launches.size();
        set_byte(2, 8'h99);
        bus.req_valid = 4'b0100;
        wait_launch(base + 1, "t5_launch");
        bus.req_valid = '0;
        repeat (10) tick();
        check("t5_mid_frame", 32'(active), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_start", 32'(bus.tx_start), 32'd0);
        check("t5_rst_data", 32'(bus.tx_data), 32'h00);
        check("t5_rst_gid", 32'(grant_id), 32'd0);
        check("t5_rst_active", 32'(active), 32'd0);
        check("t5_rst_err", 32'(err_timeout), 32'd0);
        check("t5_rst_ready", 32'(bus.req_ready), 32'd0);
        tick();
        reset = 1'b0;
        base = launches.size();
        for (int i = 0; i < 3; i++) set_byte(i, 8'(8'hA0 + i));
        bus.req_valid = 4'b0111;
        wait_launch(base + 1, "t5_post_launch");
        bus.req_valid = '0;
        check("t5_post_gid", 32'(lq(base).gid), 32'd0);
        check("t5_post_data", 32'(lq(base).data), 32'hA0);
        wait_idle("t5_post_idle");

`ifdef UART_TX_ARB_ID_EN
        // Header then payload for one accepted byte.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        base = launches.size();
        hs0 = hs_count;
        set_byte(3, 8'hC3);
        bus.req_valid = 4'b1000;
        wait_launch(base + 2, "t6_launch");
        bus.req_valid = '0;
        check("t6_hdr", 32'(lq(base).data), 32'hA3);
        check("t6_payload", 32'(lq(base + 1).data), 32'hC3);
        check("t6_one_handshake", 32'(hs_count - hs0), 32'd1);
        wait_idle("t6_idle");
`else
        hs0 = hs_count;
        check("hs_total", 32'(hs0 > 0), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
